// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control FSM (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (output Start, Op, A, B, input Hi, Lo, Busy, Done, DivZero);
  modport slave  (input Start, Op, A, B, output Hi, Lo, Busy, Done, DivZero);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / divide, one bit per clock, on operand
// magnitudes with a final sign-fix cycle that writes Hi/Lo.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic             Clk,
  input logic             Reset,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH:0]    r;       // partial product high half / partial remainder
  logic [WIDTH-1:0]  q;       // multiplier (shifting out) / dividend -> quotient
  logic [WIDTH-1:0]  m;       // multiplicand / divisor magnitude
  logic              is_div, neg_q, neg_r;
  logic [WIDTH-1:0]  hi_r, lo_r;
  logic              done_r, dz_r;

  logic [WIDTH:0]    mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  // Unsigned wrap makes |0x80000000| come out as 2^31 exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (bus.Start)
                       state_nx = !bus.Op ? S_MULT : ((bus.B == '0) ? S_DONE : S_DIV);
      S_MULT, S_DIV: if (cnt == LAST) state_nx = S_FIX;
      S_FIX, S_DONE: state_nx = S_IDLE;
      default:       state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mul_sum  = {1'b0, r[WIDTH-1:0]} + (q[0] ? {1'b0, m} : '0);
    div_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, m};
    div_diff = div_sh - {1'b0, m};
    prod     = {r[WIDTH-1:0], q};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quo_fix  = neg_q ? (~q + 1'b1) : q;
    rem_fix  = neg_r ? (~r[WIDTH-1:0] + 1'b1) : r[WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      r      <= '0;
      q      <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (bus.Start) begin
          dz_r   <= 1'b0;
          cnt    <= '0;
          r      <= '0;
          is_div <= bus.Op;
          neg_q  <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          neg_r  <= bus.A[WIDTH-1];
          q      <= bus.Op ? mag(bus.A) : mag(bus.B);
          m      <= bus.Op ? mag(bus.B) : mag(bus.A);
        end
        S_MULT: begin
          // shift {carry, high, low} right after conditionally adding m
          r   <= {1'b0, mul_sum[WIDTH:1]};
          q   <= {mul_sum[0], q[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          r   <= div_ge ? div_diff : div_sh;
          q   <= {q[WIDTH-2:0], div_ge};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          hi_r   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_r   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
          done_r <= 1'b1;
        end
        S_DONE: begin
          done_r <= 1'b1;
          dz_r   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = (state != S_IDLE);
  assign bus.Done    = done_r;
  assign bus.DivZero = dz_r;
  assign bus.Hi      = hi_r;
  assign bus.Lo      = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic against a plain-arithmetic reference model.
module tb_mult_div_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  mult_div_unit_if bus ();
  mult_div_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_dz = 1'b0;

  // Reference: signed 64-bit arithmetic, truncating division, Hi/Lo kept on /0.
  task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      p = sa * sb;
      exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0;
    end else if (b == 32'd0) begin
      exp_dz = 1'b1;
    end else begin
      qq = sa / sb; rr = sa % sb;
      exp_lo = qq[31:0]; exp_hi = rr[31:0]; exp_dz = 1'b0;
    end
  endtask

  // Issue one op, then wait (bounded) for Done; lat = edges after the Start edge.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    @(negedge Clk);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(posedge Clk); #1;
    bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.Op = $urandom_range(0, 1);
    lat = -1; busy_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge Clk); #1;
      if (bus.Done) begin lat = i; break; end
      if (bus.Busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.Hi); end
    checks++; if (bus.Lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.Lo); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", bus.DivZero); end
    @(negedge Clk); Reset = 1'b1;
  endtask

  task automatic test_mult_latency();
    int lat, bc;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, lat, bc);
    model(1'b0, 32'd7, 32'hFFFFFFFD);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_lat got=%0d exp=33", lat); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=32", bc); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got=%b exp=0", bus.Busy); end
    checks++; if (bus.Hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult7_hi got=%h exp=ffffffff", bus.Hi); end
    checks++; if (bus.Lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult7_lo got=%h exp=ffffffeb", bus.Lo); end
    checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL mult7_dz got=%b exp=0", bus.DivZero); end
    @(posedge Clk); #1;
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", bus.Done); end
  endtask

  task automatic test_mult_corners();
    int lat, bc;
    run_op(1'b0, 32'h80000000, 32'h80000000, lat, bc);
    model(1'b0, 32'h80000000, 32'h80000000);
    checks++; if (bus.Hi !== 32'h40000000) begin errors++; $display("FAIL mmin_hi got=%h exp=40000000", bus.Hi); end
    checks++; if (bus.Lo !== 32'h00000000) begin errors++; $display("FAIL mmin_lo got=%h exp=0", bus.Lo); end
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    model(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL mneg1_hi got=%h exp=0", bus.Hi); end
    checks++; if (bus.Lo !== 32'd1) begin errors++; $display("FAIL mneg1_lo got=%h exp=1", bus.Lo); end
  endtask

  task automatic test_div_corners();
    int lat, bc;
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, bc);
    model(1'b1, 32'hFFFFFFF9, 32'd2);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_lat got=%0d exp=33", lat); end
    checks++; if (bus.Lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div7_lo got=%h exp=fffffffd", bus.Lo); end
    checks++; if (bus.Hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div7_hi got=%h exp=ffffffff", bus.Hi); end
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    model(1'b1, 32'h80000000, 32'hFFFFFFFF);
    checks++; if (bus.Lo !== 32'h80000000) begin errors++; $display("FAIL divwrap_lo got=%h exp=80000000", bus.Lo); end
    checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL divwrap_hi got=%h exp=0", bus.Hi); end
    checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL divwrap_dz got=%b exp=0", bus.DivZero); end
  endtask

  task automatic test_divzero();
    int lat, bc;
    run_op(1'b1, 32'h2211, 32'h100, lat, bc);
    model(1'b1, 32'h2211, 32'h100);
    checks++; if ({bus.Hi, bus.Lo} !== {32'h11, 32'h22}) begin errors++; $display("FAIL dz_setup got=%h_%h exp=11_22", bus.Hi, bus.Lo); end
    run_op(1'b1, 32'd100, 32'd0, lat, bc);
    model(1'b1, 32'd100, 32'd0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_lat got=%0d exp=1", lat); end
    checks++; if (bus.DivZero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", bus.DivZero); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL dz_busy got=%b exp=0", bus.Busy); end
    checks++; if ({bus.Hi, bus.Lo} !== {32'h11, 32'h22}) begin errors++; $display("FAIL dz_hold got=%h_%h exp=11_22", bus.Hi, bus.Lo); end
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (bus.DivZero !== 1'b1) begin errors++; $display("FAIL dz_sticky got=%b exp=1", bus.DivZero); end
    @(negedge Clk);
    bus.Start = 1'b1; bus.Op = 1'b0; bus.A = 32'd9; bus.B = 32'd9;
    @(posedge Clk); #1; bus.Start = 1'b0;
    checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", bus.DivZero); end
    model(1'b0, 32'd9, 32'd9);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin @(posedge Clk); #1; if (bus.Done) begin lat = i; break; end end
    checks++; if (lat !== 33 || bus.Lo !== exp_lo) begin errors++; $display("FAIL dz_after lat=%0d lo=%h exp_lo=%h", lat, bus.Lo, exp_lo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] pre_hi, pre_lo, a1, b1, a3, b3;
    a1 = $urandom; b1 = $urandom; a3 = $urandom; b3 = $urandom_range(1, 1000);
    pre_hi = exp_hi; pre_lo = exp_lo;
    @(negedge Clk);
    bus.Start = 1'b1; bus.Op = 1'b0; bus.A = a1; bus.B = b1;
    @(posedge Clk); #1; bus.Start = 1'b0;
    repeat (4) begin @(posedge Clk); #1; end
    bus.Start = 1'b1; bus.Op = 1'b1; bus.A = $urandom; bus.B = $urandom;
    @(posedge Clk); #1; bus.Start = 1'b0;
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", bus.Busy); end
    checks++; if ({bus.Hi, bus.Lo} !== {pre_hi, pre_lo}) begin errors++; $display("FAIL b2b_stable got=%h_%h exp=%h_%h", bus.Hi, bus.Lo, pre_hi, pre_lo); end
    model(1'b0, a1, b1);
    lat = -1;
    for (int i = 6; i <= 100; i++) begin @(posedge Clk); #1; if (bus.Done) begin lat = i; break; end end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=33", lat); end
    checks++; if ({bus.Hi, bus.Lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL b2b_res1 got=%h_%h exp=%h_%h", bus.Hi, bus.Lo, exp_hi, exp_lo); end
    // Start in the Done cycle must be accepted
    bus.Start = 1'b1; bus.Op = 1'b1; bus.A = a3; bus.B = b3;
    pre_hi = exp_hi; pre_lo = exp_lo;
    @(posedge Clk); #1; bus.Start = 1'b0;
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", bus.Busy); end
    model(1'b1, a3, b3);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge Clk); #1;
      if (bus.Done) begin lat = i; break; end
      if (i == 20) begin
        checks++; if ({bus.Hi, bus.Lo} !== {pre_hi, pre_lo}) begin errors++; $display("FAIL b2b_hold got=%h_%h exp=%h_%h", bus.Hi, bus.Lo, pre_hi, pre_lo); end
      end
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=33", lat); end
    checks++; if ({bus.Hi, bus.Lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL b2b_res2 got=%h_%h exp=%h_%h", bus.Hi, bus.Lo, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    @(negedge Clk);
    bus.Start = 1'b1; bus.Op = 1'b0; bus.A = 32'h12345678; bus.B = 32'h9ABCDEF0;
    @(posedge Clk); #1; bus.Start = 1'b0;
    repeat (9) begin @(posedge Clk); #1; end
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", bus.Done); end
    checks++; if ({bus.Hi, bus.Lo} !== 64'd0) begin errors++; $display("FAIL rmid_hilo got=%h_%h exp=0_0", bus.Hi, bus.Lo); end
    run_op(1'b0, 32'd3, 32'd5, lat, bc);
    model(1'b0, 32'd3, 32'd5);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rmid_lat got=%0d exp=33", lat); end
    checks++; if ({bus.Hi, bus.Lo} !== {32'd0, 32'd15}) begin errors++; $display("FAIL rmid_res got=%h_%h exp=0_f", bus.Hi, bus.Lo); end
  endtask

  task automatic test_random();
    int lat, bc;
    logic op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run_op(op, a, b, lat, bc);
      model(op, a, b);
      checks++;
      if (lat !== ((op && b == 0) ? 1 : 33) || bus.Hi !== exp_hi || bus.Lo !== exp_lo || bus.DivZero !== exp_dz) begin
        errors++;
        $display("FAIL rand op=%b a=%h b=%h lat=%0d got=%h_%h dz=%b exp=%h_%h dz=%b",
                 op, a, b, lat, bus.Hi, bus.Lo, bus.DivZero, exp_hi, exp_lo, exp_dz);
      end
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = 1'b0; bus.A = '0; bus.B = '0;
    test_reset();
    test_mult_latency();
    test_mult_corners();
    test_div_corners();
    test_divzero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit beside the ALU in the multicycle datapath.
- Consumes register-file operands (A/B register outputs) on a Start strobe from the control FSM.
- Computes a signed 32x32 product (MULT) or signed quotient/remainder (DIV) iteratively, one bit per clock.
- Holds results in Hi/Lo registers read by the write-back mux for mfhi/mflo; flags divide-by-zero for the exception path.

Parameters:
- WIDTH, 32, operand/result width. The implementation is only required to support 32.
- ITER, 32, iteration cycles per operation. Must equal WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  operation request from the control FSM; sampled only when Busy=0.
- Op  input  1  0 = MULT, 1 = DIV; sampled with Start.
- A  input  32  multiplicand / dividend (two's complement).
- B  input  32  multiplier / divisor (two's complement).
- Hi  output  32  MULT: product[63:32]; DIV: remainder.
- Lo  output  32  MULT: product[31:0]; DIV: quotient.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; Hi/Lo are valid and updated this cycle.
- DivZero  output  1  last accepted DIV had B=0; sticky until the next accepted Start.

Behaviour:
- Reset (Reset=0 at a rising edge), from any state including mid-operation:
  - Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, FSM=IDLE.
  - Iteration counter and internal operand registers cleared; any in-flight result is discarded.
- FSM states: IDLE, MULT, DIV, FIX, DONE.
- IDLE, with Start=1 at edge E0:
  - Latch A, B, Op; clear DivZero; Busy=1 after E0.
  - Op=0: go to MULT.
  - Op=1 and B!=0: go to DIV.
  - Op=1 and B==0: go to DONE.
  - Start=0: stay in IDLE; outputs hold.
- MULT:
  - Radix-2 Booth or magnitude shift-add; implementer's choice, but the result must equal the exact signed 64-bit product.
  - Exactly ITER edges (E1..E32), then FIX.
- DIV:
  - Restoring or non-restoring division on operand magnitudes, one quotient bit per edge, ITER edges (E1..E32), then FIX.
- FIX (edge E33):
  - Apply sign correction and write Hi/Lo.
  - Busy=0, Done=1 after E33; next state IDLE.
  - Done returns to 0 at E34 unless a new operation completes.
- DONE (divide-by-zero path only):
  - At E1: Done=1, DivZero=1, Busy=0; Hi/Lo unchanged; next state IDLE.
- Latency: MULT/DIV = 33 edges from the Start-sampling edge to Done high. DIV by zero = 1 edge.
- Arithmetic rules:
  - MULT: {Hi,Lo} = signed(A) * signed(B), full 64 bits; cannot overflow.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
  - A=0x80000000, B=0xFFFFFFFF: Lo=0x80000000, Hi=0x00000000 (wraps, no flag).
  - Magnitude of 0x80000000 must be handled as 2^31. Internal magnitude path is 33 bits or unsigned 32-bit with correct wrap.
- Handshake:
  - Start while Busy=1 is ignored; operands are not re-latched.
  - Start is accepted in the same cycle Done=1 (FSM already back in IDLE). This gives back-to-back operations with no idle gap.
  - Op/A/B need only be valid in the Start-sampling cycle.
- Hi/Lo change only at a FIX edge or at reset. They remain stable during Busy, so reads of the prior result stay valid throughout a new operation.
- DivZero changes only on an accepted Start (cleared), the DONE edge (set), or reset.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3): Start at E0. Expect Busy=1 for E1..E32, Done=1 exactly after E33, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, DivZero=0.
- MULT A=B=0x80000000: expect Hi=0x40000000, Lo=0x00000000. Then MULT 0xFFFFFFFF*0xFFFFFFFF: expect Hi=0, Lo=1.
- DIV A=0xFFFFFFF9 (-7), B=2: expect Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF: expect Lo=0x80000000, Hi=0, DivZero=0.
- DIV A=100, B=0, with prior Hi=0x11, Lo=0x22: expect Done=1 and DivZero=1 after E1, Hi=0x11, Lo=0x22 unchanged. Next accepted Start clears DivZero.
- Reset=0 at iteration edge E10 of a MULT: after that edge Busy=0, Done=0, Hi=Lo=0. A fresh MULT 3*5 then yields Lo=15, Hi=0 at its E33.
- Start re-pulsed at E5 with different operands during Busy: result unchanged. Start asserted in the Done cycle: accepted, and the second result appears 33 edges later.
